// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : uart_ctrl_pkg                                             |
// | Brief  : Shared state encodings, widths and ALU opcodes            |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package uart_ctrl_pkg;

  localparam int c_NB_DATA  = 8;
  localparam int c_NB_OP    = 6;
  localparam int c_NB_STATE = 3;

  localparam logic [c_NB_STATE-1:0] c_WAIT_A  = 3'd0;
  localparam logic [c_NB_STATE-1:0] c_WAIT_B  = 3'd1;
  localparam logic [c_NB_STATE-1:0] c_WAIT_OP = 3'd2;
  localparam logic [c_NB_STATE-1:0] c_EXEC    = 3'd3;
  localparam logic [c_NB_STATE-1:0] c_SEND    = 3'd4;
  localparam logic [c_NB_STATE-1:0] c_WAIT_TX = 3'd5;

  // Opcode values shared with the ALU (MIPS funct style)
  localparam logic [c_NB_OP-1:0] c_OP_ADD = 6'b100000;
  localparam logic [c_NB_OP-1:0] c_OP_SUB = 6'b100010;
  localparam logic [c_NB_OP-1:0] c_OP_AND = 6'b100100;
  localparam logic [c_NB_OP-1:0] c_OP_OR  = 6'b100101;
  localparam logic [c_NB_OP-1:0] c_OP_XOR = 6'b100110;
  localparam logic [c_NB_OP-1:0] c_OP_NOR = 6'b100111;
  localparam logic [c_NB_OP-1:0] c_OP_SRA = 6'b000011;
  localparam logic [c_NB_OP-1:0] c_OP_SRL = 6'b000010;

  function automatic logic is_collecting(input logic [c_NB_STATE-1:0] s);
    return (s == c_WAIT_B) || (s == c_WAIT_OP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_timeout_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : ctrl_timeout_cnt                                          |
// | Brief  : Inter-byte timeout counter (UART_CTRL_TIMEOUT_EN only)    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
`ifdef UART_CTRL_TIMEOUT_EN
module ctrl_timeout_cnt #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int c_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_W-1:0] c_TERM = c_W'(TIMEOUT_CYC - 1);

  logic [c_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_cnt <= '0;
    else if (clear)  r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + c_W'(1);
  end

  // Terminal count only matters while actually waiting for a byte
  assign tc = enable && (r_cnt == c_TERM);

endmodule
`endif
`default_nettype wire

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : uart_alu_ctrl                                             |
// | Brief  : RX -> ALU -> TX sequencer; optional inter-byte timeout    |
// |          enabled by macro UART_CTRL_TIMEOUT_EN                     |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module uart_alu_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int NB_DATA     = c_NB_DATA,
  parameter int NB_OP       = c_NB_OP,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_done_tick,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic [NB_DATA-1:0] alu_result,
  input  logic               tx_done_tick,
  output logic [NB_DATA-1:0] op_a,
  output logic [NB_DATA-1:0] op_b,
  output logic [NB_OP-1:0]   op_code,
  output logic [NB_DATA-1:0] tx_data,
  output logic               tx_start,
  output logic               busy,
  output logic               rx_overrun,
  output logic               timeout
);

  logic [c_NB_STATE-1:0] r_state;
  logic [c_NB_STATE-1:0] w_state_nxt;
  logic w_ld_a, w_ld_b, w_ld_op, w_accept;
  logic w_drop, w_load_tx, w_bad;
  logic w_to_tc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_WAIT_A;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_WAIT_A:  if (rx_done_tick) w_state_nxt = c_WAIT_B;
      c_WAIT_B:  begin
        if (rx_done_tick) w_state_nxt = c_WAIT_OP;
        else if (w_to_tc) w_state_nxt = c_WAIT_A;
      end
      c_WAIT_OP: begin
        if (rx_done_tick) w_state_nxt = c_EXEC;
        else if (w_to_tc) w_state_nxt = c_WAIT_A;
      end
      c_EXEC:    w_state_nxt = c_SEND;
      c_SEND:    w_state_nxt = c_WAIT_TX;
      // A byte landing with tx_done starts the next frame straight away
      c_WAIT_TX: if (tx_done_tick) w_state_nxt = rx_done_tick ? c_WAIT_B : c_WAIT_A;
      default:   w_state_nxt = c_WAIT_A;
    endcase
  end

  always_comb begin
    w_ld_a    = 1'b0;
    w_ld_b    = 1'b0;
    w_ld_op   = 1'b0;
    w_drop    = 1'b0;
    w_load_tx = 1'b0;
    w_bad     = 1'b0;
    case (r_state)
      c_WAIT_A:  w_ld_a = rx_done_tick;
      c_WAIT_B:  w_ld_b = rx_done_tick;
      c_WAIT_OP: w_ld_op = rx_done_tick;
      c_EXEC:    begin
        w_load_tx = 1'b1;
        w_drop    = rx_done_tick;
      end
      c_SEND:    w_drop = rx_done_tick;
      c_WAIT_TX: begin
        if (tx_done_tick) w_ld_a = rx_done_tick;
        else              w_drop = rx_done_tick;
      end
      default:   w_bad = 1'b1;
    endcase
  end

  assign w_accept = w_ld_a | w_ld_b | w_ld_op;
  assign busy     = (r_state != c_WAIT_A);

  // tx_data is loaded on the edge entering SEND so it is valid alongside tx_start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      tx_start   <= w_load_tx;
      rx_overrun <= w_drop;
      if (w_bad) begin
        op_a    <= '0;
        op_b    <= '0;
        op_code <= '0;
      end
      if (w_ld_a)    op_a    <= rx_data;
      if (w_ld_b)    op_b    <= rx_data;
      if (w_ld_op)   op_code <= rx_data[NB_OP-1:0];
      if (w_load_tx) tx_data <= alu_result;
    end
  end

`ifdef UART_CTRL_TIMEOUT_EN
  logic w_to_en, w_to_clear, r_timeout;

  assign w_to_en    = is_collecting(r_state);
  assign w_to_clear = w_accept || (w_state_nxt == c_WAIT_A);

  ctrl_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_to_clear),
    .enable (w_to_en),
    .tc     (w_to_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_timeout <= 1'b0;
    else        r_timeout <= w_to_tc && !rx_done_tick;
  end

  assign timeout = r_timeout;
`else
  assign w_to_tc = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire
